// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer for the MIPS core: walks IF/ID/EXE/MEM/WB/BR/JMP/HALT
// and decodes the IR opcode/funct into every datapath enable and select.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       pcwr,
  output logic       irwr,
  output logic       regwr,
  output logic       dmrd,
  output logic       dmwr,
  output logic [1:0] npc_op,
  output logic [2:0] alu_op,
  output logic [1:0] ext_op,
  output logic       bsel,
  output logic [1:0] regdst,
  output logic [1:0] wdsel,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] state
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EXE  = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_BR   = 3'd5;
  localparam logic [2:0] S_JMP  = 3'd6;
  localparam logic [2:0] S_HALT = 3'd7;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HI   = 2'b10;

  logic [2:0] state_q, state_d;
  logic       illegal_q, illegal_d;

  logic rtype;
  logic is_addu, is_subu, is_jr;
  logic is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_j, is_jal;
  logic is_alu, is_jmp;

  assign rtype   = (opcode == 6'b000000);
  assign is_addu = rtype & (funct == 6'b100001);
  assign is_subu = rtype & (funct == 6'b100011);
  assign is_jr   = rtype & (funct == 6'b001000);
  assign is_ori  = (opcode == 6'b001101);
  assign is_lui  = (opcode == 6'b001111);
  assign is_lw   = (opcode == 6'b100011);
  assign is_sw   = (opcode == 6'b101011);
  assign is_beq  = (opcode == 6'b000100);
  assign is_j    = (opcode == 6'b000010);
  assign is_jal  = (opcode == 6'b000011);

  assign is_alu = is_addu | is_subu | is_ori
                | is_lui | is_lw | is_sw;
  assign is_jmp = is_j | is_jal | is_jr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IF;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        unique case (1'b1)
          is_alu:  state_d = S_EXE;
          is_beq:  state_d = S_BR;
          is_jmp:  state_d = S_JMP;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXE: state_d = (is_lw | is_sw) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ack) state_d = is_lw ? S_WB : S_IF;
      end
      S_WB:   state_d = S_IF;
      S_BR:   state_d = S_IF;
      S_JMP:  state_d = S_IF;
      S_HALT: state_d = S_HALT;
    endcase
  end

  // ALU/extender selects of the decoded instruction, held from EXE to WB
  logic [2:0] alu_x;
  logic [1:0] ext_x;
  logic       bsel_x;

  always_comb begin
    alu_x  = ALU_ADD;
    ext_x  = EXT_ZERO;
    bsel_x = 1'b0;
    unique case (1'b1)
      is_subu: alu_x = ALU_SUB;
      is_ori: begin
        ext_x  = EXT_ZERO;
        bsel_x = 1'b1;
        alu_x  = ALU_OR;
      end
      is_lui: begin
        ext_x  = EXT_HI;
        bsel_x = 1'b1;
      end
      is_lw, is_sw: begin
        ext_x  = EXT_SIGN;
        bsel_x = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    pcwr   = 1'b0;
    irwr   = 1'b0;
    regwr  = 1'b0;
    dmrd   = 1'b0;
    dmwr   = 1'b0;
    npc_op = 2'b00;
    alu_op = ALU_ADD;
    ext_op = EXT_ZERO;
    bsel   = 1'b0;
    regdst = 2'b00;
    wdsel  = 2'b00;
    retire = 1'b0;
    if (rst) begin
      unique case (state_q)
        S_IF: begin
          irwr = 1'b1;
          pcwr = 1'b1;
        end
        S_ID: ;
        S_EXE: begin
          alu_op = alu_x;
          ext_op = ext_x;
          bsel   = bsel_x;
        end
        S_MEM: begin
          alu_op = alu_x;
          ext_op = ext_x;
          bsel   = bsel_x;
          dmrd   = is_lw;
          dmwr   = is_sw;
          retire = is_sw & mem_ack;
        end
        S_WB: begin
          alu_op = alu_x;
          ext_op = ext_x;
          bsel   = bsel_x;
          regwr  = 1'b1;
          retire = 1'b1;
          regdst = rtype ? 2'b01 : 2'b00;
          wdsel  = is_lw ? 2'b01 : 2'b00;
        end
        S_BR: begin
          alu_op = ALU_SUB;
          npc_op = 2'b01;
          pcwr   = zero;
          retire = 1'b1;
        end
        S_JMP: begin
          pcwr   = 1'b1;
          retire = 1'b1;
          npc_op = is_jr ? 2'b11 : 2'b10;
          if (is_jal) begin
            regwr  = 1'b1;
            regdst = 2'b10;
            wdsel  = 2'b10;
          end
        end
        S_HALT: ;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed vector table, randomized instruction stream
// against a per-instruction summary model, and hand-written corner sequences.
module tb_mc_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ack;
  logic       pcwr, irwr, regwr, dmrd, dmwr;
  logic [1:0] npc_op;
  logic [2:0] alu_op;
  logic [1:0] ext_op;
  logic       bsel;
  logic [1:0] regdst;
  logic [1:0] wdsel;
  logic       retire;
  logic       illegal;
  logic [2:0] state;

  mc_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .funct   (funct),
    .zero    (zero),
    .mem_ack (mem_ack),
    .pcwr    (pcwr),
    .irwr    (irwr),
    .regwr   (regwr),
    .dmrd    (dmrd),
    .dmwr    (dmwr),
    .npc_op  (npc_op),
    .alu_op  (alu_op),
    .ext_op  (ext_op),
    .bsel    (bsel),
    .regdst  (regdst),
    .wdsel   (wdsel),
    .retire  (retire),
    .illegal (illegal),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp)
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else
      n_pass++;
  endtask

  // instruction classes
  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4;
  localparam int K_SW = 5, K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9;

  logic [5:0] op_tab [10];
  logic [5:0] fn_tab [10];

  typedef struct {
    int cyc;
    int npcwr;
    int nregwr;
    int ndmrd;
    int ndmwr;
    int rdst;
    int wds;
    int npc;
    int alu;
    int ext;
    int bs;
  } obs_t;

  typedef struct {
    int   k;
    logic z;
    int   w;
    obs_t e;
  } vec_t;

  obs_t o;
  int   o_irwr;
  int   st_q[$];

  // Run one instruction from the low phase of its IF cycle to the low
  // phase of the following IF cycle; summarise what was observed.
  task automatic run_instr(input int k, input logic z, input int w);
    int memcnt;
    bit done;
    opcode  = op_tab[k];
    funct   = fn_tab[k];
    zero    = z;
    mem_ack = 1'b0;
    memcnt  = 0;
    done    = 0;
    o       = '{default: 0};
    o_irwr  = 0;
    st_q.delete();
    for (int c = 0; c < 30 && !done; c++) begin
      if (dmrd | dmwr) begin
        mem_ack = (memcnt == w);
        memcnt++;
      end else begin
        mem_ack = 1'b0;
      end
      #1;
      o.cyc++;
      st_q.push_back(int'(state));
      o.npcwr  += int'(pcwr);
      o_irwr   += int'(irwr);
      o.nregwr += int'(regwr);
      o.ndmrd  += int'(dmrd);
      o.ndmwr  += int'(dmwr);
      if (retire) begin
        done  = 1;
        o.rdst = int'(regdst);
        o.wds  = int'(wdsel);
        o.npc  = int'(npc_op);
        o.alu  = int'(alu_op);
        o.ext  = int'(ext_op);
        o.bs   = int'(bsel);
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk("retire_seen", int'(done), 1);
  endtask

  // Summary model straight from the instruction rules
  function automatic obs_t model(input int k, input logic z, input int w);
    obs_t e;
    bit br, jp, ld, st;
    br = (k == K_BEQ);
    jp = (k == K_J) || (k == K_JAL) || (k == K_JR);
    ld = (k == K_LW);
    st = (k == K_SW);
    e = '{default: 0};
    e.cyc    = (br || jp) ? 3 : ld ? 5 + w : st ? 4 + w : 4;
    e.npcwr  = 1 + int'(jp) + int'(br && z);
    e.nregwr = (br || st || k == K_J || k == K_JR) ? 0 : 1;
    e.ndmrd  = ld ? w + 1 : 0;
    e.ndmwr  = st ? w + 1 : 0;
    e.rdst   = (k == K_ADDU || k == K_SUBU) ? 1 : (k == K_JAL) ? 2 : 0;
    e.wds    = ld ? 1 : (k == K_JAL) ? 2 : 0;
    e.npc    = br ? 1 : (k == K_J || k == K_JAL) ? 2 : (k == K_JR) ? 3 : 0;
    e.alu    = (k == K_SUBU || br) ? 1 : (k == K_ORI) ? 2 : 0;
    e.ext    = (k == K_LUI) ? 2 : (ld || st) ? 1 : 0;
    e.bs     = (k == K_ORI || k == K_LUI || ld || st) ? 1 : 0;
    return e;
  endfunction

  task automatic cmp_obs(input string tag, input obs_t e);
    chk({tag, ".cycles"}, o.cyc, e.cyc);
    chk({tag, ".pcwr_n"}, o.npcwr, e.npcwr);
    chk({tag, ".irwr_n"}, o_irwr, 1);
    chk({tag, ".regwr_n"}, o.nregwr, e.nregwr);
    chk({tag, ".dmrd_n"}, o.ndmrd, e.ndmrd);
    chk({tag, ".dmwr_n"}, o.ndmwr, e.ndmwr);
    chk({tag, ".regdst"}, o.rdst, e.rdst);
    chk({tag, ".wdsel"}, o.wds, e.wds);
    chk({tag, ".npc_op"}, o.npc, e.npc);
    chk({tag, ".alu_op"}, o.alu, e.alu);
    chk({tag, ".ext_op"}, o.ext, e.ext);
    chk({tag, ".bsel"}, o.bs, e.bs);
  endtask

  vec_t vt[$];

  function automatic int en_bits();
    return int'({pcwr, irwr, regwr, dmrd, dmwr, retire});
  endfunction

  initial begin
    n_pass = 0;
    n_total = 0;
    op_tab = '{6'b000000, 6'b000000, 6'b001101, 6'b001111, 6'b100011,
               6'b101011, 6'b000100, 6'b000010, 6'b000011, 6'b000000};
    fn_tab = '{6'b100001, 6'b100011, 6'b000000, 6'b000000, 6'b000000,
               6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000};

    //           k       z  w   cyc pc rw rd wr rdst wds npc alu ext bs
    vt.push_back('{K_ADDU, 0, 0, '{4, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0}});
    vt.push_back('{K_SUBU, 0, 0, '{4, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0}});
    vt.push_back('{K_ORI,  0, 0, '{4, 1, 1, 0, 0, 0, 0, 0, 2, 0, 1}});
    vt.push_back('{K_LUI,  0, 0, '{4, 1, 1, 0, 0, 0, 0, 0, 0, 2, 1}});
    vt.push_back('{K_LW,   0, 0, '{5, 1, 1, 1, 0, 0, 1, 0, 0, 1, 1}});
    vt.push_back('{K_LW,   0, 2, '{7, 1, 1, 3, 0, 0, 1, 0, 0, 1, 1}});
    vt.push_back('{K_SW,   0, 0, '{4, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1}});
    vt.push_back('{K_SW,   0, 1, '{5, 1, 0, 0, 2, 0, 0, 0, 0, 1, 1}});
    vt.push_back('{K_BEQ,  1, 0, '{3, 2, 0, 0, 0, 0, 0, 1, 1, 0, 0}});
    vt.push_back('{K_BEQ,  0, 0, '{3, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0}});
    vt.push_back('{K_J,    0, 0, '{3, 2, 0, 0, 0, 0, 0, 2, 0, 0, 0}});
    vt.push_back('{K_JAL,  0, 0, '{3, 2, 1, 0, 0, 2, 2, 2, 0, 0, 0}});
    vt.push_back('{K_JR,   0, 0, '{3, 2, 0, 0, 0, 0, 0, 3, 0, 0, 0}});

    // reset held for two edges: enables and selects gated off
    rst = 1'b0;
    opcode = 6'b000000;
    funct = 6'b100001;
    zero = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.state", int'(state), 0);
    chk("rst.illegal", int'(illegal), 0);
    chk("rst.enables", en_bits(), 0);
    chk("rst.npc_op", int'(npc_op), 0);
    rst = 1'b1;

    // addu after reset: state path and enables
    run_instr(K_ADDU, 1'b0, 0);
    chk("addu.cycles", o.cyc, 4);
    chk("addu.st_len", st_q.size(), 4);
    if (st_q.size() == 4) begin
      chk("addu.st0", st_q[0], 0);
      chk("addu.st1", st_q[1], 1);
      chk("addu.st2", st_q[2], 2);
      chk("addu.st3", st_q[3], 4);
    end
    chk("addu.regdst", o.rdst, 1);

    // directed table
    foreach (vt[i]) begin
      run_instr(vt[i].k, vt[i].z, vt[i].w);
      cmp_obs($sformatf("vec%0d", i), vt[i].e);
    end

    // randomized stream against the model
    for (int i = 0; i < 40; i++) begin
      int   k;
      int   w;
      logic z;
      k = $urandom_range(0, 9);
      w = $urandom_range(0, 3);
      z = 1'($urandom_range(0, 1));
      run_instr(k, z, w);
      cmp_obs($sformatf("rnd%0d_k%0d", i, k), model(k, z, w));
    end

    // illegal opcode: HALT, sticky flag, no enables
    opcode = 6'b111111;
    funct = 6'b000000;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ill.state", int'(state), 7);
    chk("ill.flag", int'(illegal), 1);
    for (int c = 0; c < 10; c++) begin
      chk("ill.enables", en_bits(), 0);
      chk("ill.hold", int'(state), 7);
      @(negedge clk);
      #1;
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("ill.rst_state", int'(state), 0);
    chk("ill.rst_flag", int'(illegal), 0);
    rst = 1'b1;

    // legal instruction still runs after leaving HALT
    run_instr(K_ORI, 1'b0, 0);
    cmp_obs("post_halt_ori", model(K_ORI, 1'b0, 0));

    // reset during a sw memory wait
    opcode = op_tab[K_SW];
    funct = fn_tab[K_SW];
    mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("swrst.in_mem", int'(state), 3);
    chk("swrst.dmwr_before", int'(dmwr), 1);
    @(negedge clk);
    #1;
    chk("swrst.wait_state", int'(state), 3);
    rst = 1'b0;
    #1;
    chk("swrst.dmwr_in_rst", int'(dmwr), 0);
    chk("swrst.enables", en_bits(), 0);
    @(negedge clk);
    #1;
    chk("swrst.next_state", int'(state), 0);
    rst = 1'b1;

    run_instr(K_JAL, 1'b0, 0);
    cmp_obs("post_rst_jal", model(K_JAL, 1'b0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencer for the MIPS core. It walks each instruction through fetch, decode, execute, memory and write-back states. From the opcode and funct fields held in the instruction register, it generates every datapath enable and select: PC write enable, IR write, register-file write, data-memory read/write, and the NPC, ALU, extender and mux selects. It is the only driver of the PC's `pcwr` input, and it stalls on a data-memory acknowledge handshake.

## Interface
Parameters:
- none; state and opcode encodings are fixed below.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `opcode` in 6: instr[31:26] from the IR.
- `funct` in 6: instr[5:0] from the IR.
- `zero` in 1: ALU zero flag.
- `mem_ack` in 1: data-memory acknowledge; sampled while in MEM.
- `pcwr` out 1: PC write enable.
- `irwr` out 1: IR write enable.
- `regwr` out 1: register-file write enable.
- `dmrd` out 1: data-memory read strobe.
- `dmwr` out 1: data-memory write strobe.
- `npc_op` out 2: next-PC select; 00 PC+4, 01 branch, 10 jump target, 11 register (jr).
- `alu_op` out 3: 000 add, 001 sub, 010 or.
- `ext_op` out 2: 00 zero-extend, 01 sign-extend, 10 imm<<16.
- `bsel` out 1: ALU B operand; 0 register rt, 1 extended immediate.
- `regdst` out 2: destination register; 00 rt, 01 rd, 10 $31.
- `wdsel` out 2: write-back data; 00 ALU, 01 memory, 10 PC+4.
- `retire` out 1: one-cycle pulse in the final state of each instruction.
- `illegal` out 1: sticky flag, set on an undecodable instruction.
- `state` out 3: current state, for debug.

## Operation
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4, BR=5, JMP=6, HALT=7.
- Supported instructions: addu (R, funct 100001), subu (R, funct 100011), jr (R, funct 001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- IF: `irwr`=1, `pcwr`=1, `npc_op`=00. Next state is ID.
- ID: no write enables asserted.
  - addu, subu, ori, lui, lw, sw go to EXE.
  - beq goes to BR.
  - j, jal, jr go to JMP.
  - Anything else goes to HALT and sets `illegal`.
- EXE: drives the ALU controls for the decoded instruction.
  - addu/subu: `bsel`=0, `alu_op` add/sub.
  - ori: `ext_op`=00, `bsel`=1, `alu_op`=or.
  - lui: `ext_op`=10, `bsel`=1, `alu_op`=add (rs is $0 by ISA).
  - lw/sw: `ext_op`=01, `bsel`=1, `alu_op`=add.
  - Next state: lw/sw go to MEM; all others go to WB.
- MEM: `dmrd`=1 for lw, `dmwr`=1 for sw; the lw/sw controls from EXE are held.
  - Stays in MEM while `mem_ack`=0.
  - On `mem_ack`=1: lw goes to WB; sw asserts `retire` and goes to IF.
- WB: `regwr`=1, `retire`=1. Next state is IF.
  - R-type: `regdst`=01, `wdsel`=00.
  - ori/lui: `regdst`=00, `wdsel`=00.
  - lw: `regdst`=00, `wdsel`=01.
  - The EXE ALU/extender selects are held so the ALU result stays stable.
- BR: `alu_op`=sub, `bsel`=0, `npc_op`=01, `pcwr`=`zero`, `retire`=1. Next state is IF.
- JMP: `pcwr`=1, `retire`=1. Next state is IF.
  - j/jal: `npc_op`=10.
  - jr: `npc_op`=11.
  - jal additionally: `regwr`=1, `regdst`=10, `wdsel`=10.
- HALT: all enables 0. Stays in HALT until reset.
- NPC computes targets from the PC already incremented in IF, i.e. PC+4 of the current instruction.
- Defaults: any output not listed for a state is 0.

## Timing
- Reset: `rst`=0 at a rising edge forces state to IF and clears `illegal`.
  - While `rst`=0, `pcwr`, `irwr`, `regwr`, `dmrd`, `dmwr` and `retire` are forced to 0 combinationally.
  - All select outputs read 0 during reset.
- Outputs are combinational from state, opcode and funct; `pcwr` in BR also depends on `zero`. Only state and `illegal` are registered.
- Latency with zero memory wait:
  - beq, j, jal, jr: 3 cycles.
  - addu, subu, ori, lui, sw: 4 cycles.
  - lw: 5 cycles.
  - Each cycle `mem_ack` stays low adds one cycle to lw or sw.
- `mem_ack` high on the first MEM cycle completes with no wait. `dmrd`/`dmwr` stay high on every MEM cycle up to and including the ack cycle.
- Reset asserted during a MEM wait: next state is IF. No write enable is asserted in the reset cycle.
- `opcode`/`funct` only change after IF because `irwr` is high only in IF. The decode in ID/EXE/MEM/WB/BR/JMP uses the live IR fields.
- `illegal` stays 1 until reset.

## Test plan
- Reset then addu: hold `rst`=0 for 2 cycles, release, issue opcode 000000 funct 100001. Required: states IF→ID→EXE→WB; `pcwr`/`irwr` high only in IF; `regwr`=1 with `regdst`=01 in WB; `retire` on cycle 4.
- lw with 2-cycle wait: drive `mem_ack` low for 2 MEM cycles, then high. Required: `dmrd`=1 for 3 cycles; then WB with `wdsel`=01; total 7 cycles.
- beq taken and not taken: with `zero`=1, `pcwr`=1 and `npc_op`=01 in BR; with `zero`=0, `pcwr`=0. Both retire in 3 cycles.
- jal then jr: jal gives `pcwr`=1, `npc_op`=10, `regwr`=1, `regdst`=10, `wdsel`=10. jr gives `npc_op`=11 and `regwr`=0.
- Illegal opcode 111111: required: HALT (state 7), `illegal`=1, no enables for 10 cycles; reset returns the block to IF with `illegal`=0.
- Reset during a sw wait: assert `rst`=0 while in MEM. Required: `dmwr` drops in that cycle and the next state is IF.
